// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states
// and STATUS register layout.
// Optional build macro: INTR_VECTOR_TABLE_EN (per-source handler vectors).
package intr_pkg;

    // Register map (word indices on the wr_addr / rd_addr buses)
    localparam int unsigned ADDR_PENDING   = 32'd0;
    localparam int unsigned ADDR_ENABLE    = 32'd1;
    localparam int unsigned ADDR_VECTOR    = 32'd2;
    localparam int unsigned ADDR_STATUS    = 32'd3;
    localparam int unsigned ADDR_VEC_TABLE = 32'd4;

    // STATUS layout: in_service and irq in the top bits, irq_id in the LSBs
    localparam int unsigned STATUS_IN_SERVICE_BIT = 31;
    localparam int unsigned STATUS_IRQ_BIT        = 30;

    // Request/service life cycle of one interrupt
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intr_state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder: bit 0 has the highest priority.
// Purely combinational; valid_o is low when no request bit is set.
module intr_prio_enc
    import intr_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req_i,
    output logic [ID_W-1:0]  id_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set index is the last to write
    always_comb begin
        id_o    = '0;
        valid_o = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o    = ID_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Parametrised interrupt controller.
// Rising edges on src_req latch into pending bits; pending & enable is
// arbitrated (source 0 highest) and a single registered irq is raised with
// the winning id and handler vector. Software clears pending bits with a
// write-1-to-clear; taking the interrupt does not acknowledge it.
// Optional build macro: INTR_VECTOR_TABLE_EN
//   defined   : one vector register per source at addr 4+i, VECTOR reads 0
//   undefined : a single VECTOR register serves every source
//
// Handshake: irq stays high from the cycle after arbitration until the CPU
// pulses irq_take (accepted only in REQ) or the masked pending set drops to
// zero; iret is accepted only in SERVICE and returns the FSM to IDLE.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int VEC_W  = 32,
`ifdef INTR_VECTOR_TABLE_EN
    // Addresses 4..4+N_SRC-1 must fit; widen further for very large N_SRC
    parameter int ADDR_W = (N_SRC > 4) ? 4 : 3,
`else
    parameter int ADDR_W = 3,
`endif
    parameter int ID_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  src_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              irq,
    output logic [ID_W-1:0]   irq_id,
    output logic [VEC_W-1:0]  irq_vec,
    input  logic              irq_take,
    input  logic              iret,
    output logic              in_service
);

    // ------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] src_prev_q;
    logic [N_SRC-1:0] src_rise;
    logic [N_SRC-1:0] w1c_mask;
    logic [N_SRC-1:0] active;

    // FSM state and its registered outputs
    intr_state_t      state_q;
    logic             irq_q;
    logic             in_service_q;
    logic [ID_W-1:0]  irq_id_q;
    logic [VEC_W-1:0] irq_vec_q;

    // Arbitration result for the current cycle
    logic [ID_W-1:0]  win_id;
    logic             win_valid;
    logic [VEC_W-1:0] win_vec;

    // Addresses widened to 32 bits so decode never aliases on a narrow bus
    logic [31:0] wr_addr_ext;
    logic [31:0] rd_addr_ext;
    logic        wr_pending;
    logic        wr_enable;

    assign wr_addr_ext = 32'(wr_addr);
    assign rd_addr_ext = 32'(rd_addr);
    assign wr_pending  = wr_en && (wr_addr_ext == ADDR_PENDING);
    assign wr_enable   = wr_en && (wr_addr_ext == ADDR_ENABLE);

    // ------------------------------------------------------------------
    // Pending / enable next-state: a new rising edge beats a W1C of the
    // same bit in the same cycle, so no request is ever lost.
    // ------------------------------------------------------------------
    assign src_rise  = src_req & ~src_prev_q;
    assign w1c_mask  = wr_pending ? wr_data[N_SRC-1:0] : '0;
    assign pending_d = (pending_q & ~w1c_mask) | src_rise;
    assign enable_d  = wr_enable ? wr_data[N_SRC-1:0] : enable_q;
    assign active    = pending_q & enable_q;

    // Pending, enable and edge-detect history registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            enable_q   <= '0;
            src_prev_q <= '0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            src_prev_q <= src_req;
        end
    end

    // ------------------------------------------------------------------
    // Handler vector storage
    // ------------------------------------------------------------------
`ifdef INTR_VECTOR_TABLE_EN
    logic [VEC_W-1:0] vec_tbl_q [N_SRC];
    logic [N_SRC-1:0] vec_wr;

    // Per-entry write strobes for the vector table at addr 4+i
    always_comb begin
        vec_wr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            vec_wr[i] = wr_en && (wr_addr_ext == ADDR_VEC_TABLE + 32'(i));
        end
    end

    // Vector table registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                vec_tbl_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (vec_wr[i]) begin
                    vec_tbl_q[i] <= VEC_W'(wr_data);
                end
            end
        end
    end

    // Select the winner's vector (loop avoids out-of-range indexing)
    always_comb begin
        win_vec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (win_id == ID_W'(i)) begin
                win_vec = vec_tbl_q[i];
            end
        end
    end
`else
    logic [VEC_W-1:0] vec_base_q;

    // Single shared handler base address
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_base_q <= '0;
        end else if (wr_en && (wr_addr_ext == ADDR_VECTOR)) begin
            vec_base_q <= VEC_W'(wr_data);
        end
    end

    assign win_vec = vec_base_q;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    intr_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req_i   (active),
        .id_o    (win_id),
        .valid_o (win_valid)
    );

    // ------------------------------------------------------------------
    // Request FSM: id and vector are latched on entry to REQ and held, so
    // a higher-priority arrival does not change what the CPU was offered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            irq_q        <= 1'b0;
            in_service_q <= 1'b0;
            irq_id_q     <= '0;
            irq_vec_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q   <= REQ;
                        irq_q     <= 1'b1;
                        irq_id_q  <= win_id;
                        irq_vec_q <= win_vec;
                    end
                end
                REQ: begin
                    if (irq_take) begin
                        state_q      <= SERVICE;
                        irq_q        <= 1'b0;
                        in_service_q <= 1'b1;
                    end else if (!win_valid) begin
                        // Acked or masked before the CPU trapped: withdraw
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                SERVICE: begin
                    // No nesting: new pending bits wait until iret
                    if (iret) begin
                        state_q      <= IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    irq_q        <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Combinational register read mux; unmapped and unused bits read 0
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        case (rd_addr_ext)
            ADDR_PENDING: rd_data[N_SRC-1:0] = pending_q;
            ADDR_ENABLE:  rd_data[N_SRC-1:0] = enable_q;
`ifndef INTR_VECTOR_TABLE_EN
            ADDR_VECTOR:  rd_data = 32'(vec_base_q);
`endif
            ADDR_STATUS: begin
                rd_data[STATUS_IN_SERVICE_BIT] = in_service_q;
                rd_data[STATUS_IRQ_BIT]        = irq_q;
                rd_data[ID_W-1:0]              = irq_id_q;
            end
            default: rd_data = '0;
        endcase
`ifdef INTR_VECTOR_TABLE_EN
        for (int i = 0; i < N_SRC; i++) begin
            if (rd_addr_ext == ADDR_VEC_TABLE + 32'(i)) begin
                rd_data = 32'(vec_tbl_q[i]);
            end
        end
`endif
    end

    assign irq        = irq_q;
    assign irq_id     = irq_id_q;
    assign irq_vec    = irq_vec_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl with hand-computed expectations.
// Build with INTR_VECTOR_TABLE_EN defined to cover the per-source vectors.
module tb_intr_ctrl;

    localparam int N_SRC  = 4;
    localparam int VEC_W  = 32;
    localparam int ADDR_W = 3;
    localparam int ID_W   = 2;

    logic              clk;
    logic              reset;
    logic [N_SRC-1:0]  src_req;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              irq;
    logic [ID_W-1:0]   irq_id;
    logic [VEC_W-1:0]  irq_vec;
    logic              irq_take;
    logic              iret;
    logic              in_service;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    intr_ctrl #(
        .N_SRC  (N_SRC),
        .VEC_W  (VEC_W),
        .ADDR_W (ADDR_W),
        .ID_W   (ID_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src_req    (src_req),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .irq        (irq),
        .irq_id     (irq_id),
        .irq_vec    (irq_vec),
        .irq_take   (irq_take),
        .iret       (iret),
        .in_service (in_service)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; land 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        step();
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
        rd_addr = ADDR_W'(a);
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic pulse(input logic [N_SRC-1:0] mask);
        src_req = mask;
        step();
        src_req = '0;
    endtask

    task automatic take();
        irq_take = 1'b1;
        step();
        irq_take = 1'b0;
    endtask

    task automatic ret();
        iret = 1'b1;
        step();
        iret = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int hi_cnt;
        reset    = 1'b1;
        src_req  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        irq_take = 1'b0;
        iret     = 1'b0;
        step();
        step();

        // Reset state
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_in_service", 32'(in_service), 32'h0);
        check("rst_irq_id", 32'(irq_id), 32'h0);
        check("rst_irq_vec", irq_vec, 32'h0);
        rd_chk("rst_pending", 0, 32'h0);
        rd_chk("rst_status", 3, 32'h0);
        reset = 1'b0;
        step();

        // Case 1: single source, latency and id/vector
        wr_reg(1, 32'h2);
`ifdef INTR_VECTOR_TABLE_EN
        wr_reg(4, 32'h9);
        wr_reg(5, 32'h9);
`else
        wr_reg(2, 32'h9);
`endif
        pulse(4'b0010);
        check("c1_irq_t1", 32'(irq), 32'h0);
        rd_chk("c1_pending", 0, 32'h2);
        step();
        check("c1_irq_t2", 32'(irq), 32'h1);
        check("c1_irq_id", 32'(irq_id), 32'h1);
        check("c1_irq_vec", irq_vec, 32'h9);
        rd_chk("c1_status", 3, 32'h4000_0001);

        // Case 2: take, ack, iret
        take();
        check("c2_irq", 32'(irq), 32'h0);
        check("c2_in_service", 32'(in_service), 32'h1);
        rd_chk("c2_status", 3, 32'h8000_0001);
        wr_reg(0, 32'h2);
        rd_chk("c2_pending", 0, 32'h0);
        ret();
        check("c2_in_service_off", 32'(in_service), 32'h0);
        step();
        check("c2_irq_after_iret", 32'(irq), 32'h0);

        // Case 3: no ack before iret -> re-assert one cycle after IDLE
        pulse(4'b0010);
        step();
        check("c3_irq", 32'(irq), 32'h1);
        take();
        ret();
        check("c3_irq_at_idle", 32'(irq), 32'h0);
        step();
        check("c3_irq_reassert", 32'(irq), 32'h1);
        check("c3_irq_id", 32'(irq_id), 32'h1);
        // Ack while in REQ without a take: request is withdrawn
        wr_reg(0, 32'h2);
        check("c3_irq_hold", 32'(irq), 32'h1);
        step();
        check("c3_req_drop", 32'(irq), 32'h0);

        // Case 4: masked source, then enable
        wr_reg(1, 32'h0);
        pulse(4'b0001);
        rd_chk("c4_pending", 0, 32'h1);
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (irq) hi_cnt++;
        end
        check("c4_masked_irq_cycles", 32'(hi_cnt), 32'h0);
        wr_reg(1, 32'h1);
        check("c4_irq_t1", 32'(irq), 32'h0);
        step();
        check("c4_irq_t2", 32'(irq), 32'h1);
        check("c4_irq_id", 32'(irq_id), 32'h0);
        check("c4_irq_vec", irq_vec, 32'h9);
        // take and iret together in REQ: only take acts
        irq_take = 1'b1;
        iret     = 1'b1;
        step();
        irq_take = 1'b0;
        iret     = 1'b0;
        check("c4_both_in_req", 32'(in_service), 32'h1);
        wr_reg(0, 32'h1);
        // take and iret together in SERVICE: only iret acts
        irq_take = 1'b1;
        iret     = 1'b1;
        step();
        irq_take = 1'b0;
        iret     = 1'b0;
        check("c4_both_in_service", 32'(in_service), 32'h0);
        step();
        check("c4_irq_idle", 32'(irq), 32'h0);

        // Set beats W1C of the same bit; held level does not re-set
        wr_reg(1, 32'h0);
        src_req = 4'b0001;
        wr_reg(0, 32'h1);
        rd_chk("set_wins", 0, 32'h1);
        wr_reg(0, 32'h1);
        step();
        rd_chk("level_no_reset", 0, 32'h0);
        src_req = '0;
        step();

        // Case 5: two sources at once, priority and no nesting
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h3);
        wr_reg(1, 32'hF);
        pulse(4'b1100);
        step();
        check("c5_irq_first", 32'(irq), 32'h1);
        check("c5_id_first", 32'(irq_id), exp_q.pop_front());
        take();
        step();
        step();
        check("c5_no_nest", 32'(irq), 32'h0);
        wr_reg(0, 32'h4);
        ret();
        step();
        check("c5_irq_second", 32'(irq), 32'h1);
        check("c5_id_second", 32'(irq_id), exp_q.pop_front());
        take();
        wr_reg(0, 32'h8);
        ret();
        step();
        check("c5_irq_done", 32'(irq), 32'h0);
        rd_chk("c5_pending", 0, 32'h0);

        // Read-only and unmapped addresses
        wr_reg(3, 32'hFFFF_FFFF);
        rd_chk("status_ro", 3, 32'h3);
`ifdef INTR_VECTOR_TABLE_EN
        wr_reg(2, 32'h55);
        rd_chk("vector_unused", 2, 32'h0);
`else
        wr_reg(5, 32'h55);
        rd_chk("unmapped_5", 5, 32'h0);
        rd_chk("unmapped_4", 4, 32'h0);
`endif

        // Case 6: vector selection, then reset while in SERVICE
`ifdef INTR_VECTOR_TABLE_EN
        wr_reg(7, 32'h40);
        wr_reg(4, 32'h20);
        rd_chk("c6_vec3", 7, 32'h40);
        rd_chk("c6_vec0", 4, 32'h20);
`else
        wr_reg(2, 32'h40);
        rd_chk("c6_vector", 2, 32'h40);
`endif
        pulse(4'b1000);
        step();
        check("c6_irq", 32'(irq), 32'h1);
        check("c6_irq_id", 32'(irq_id), 32'h3);
        check("c6_irq_vec", irq_vec, 32'h40);
        take();
        check("c6_in_service", 32'(in_service), 32'h1);
        reset = 1'b1;
        step();
        check("c6_rst_in_service", 32'(in_service), 32'h0);
        check("c6_rst_irq", 32'(irq), 32'h0);
        check("c6_rst_irq_vec", irq_vec, 32'h0);
        rd_chk("c6_rst_pending", 0, 32'h0);
        rd_chk("c6_rst_enable", 1, 32'h0);
        rd_chk("c6_rst_vector", 2, 32'h0);
        rd_chk("c6_rst_status", 3, 32'h0);
        step();
        rd_chk("c6_rst_addr4", 4, 32'h0);
        rd_chk("c6_rst_addr7", 7, 32'h0);
        reset = 1'b0;
        step();
        step();
        check("c6_idle_after_rst", 32'(irq), 32'h0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Parametrised interrupt controller, successor to the single-source UART interrupt logic inside cpu. Latches N_SRC peripheral requests into pending bits, masks them with an enable register, and raises one registered irq with the winning source id and handler vector. Tracks in-service state until the CPU executes iret. Software clears pending bits explicitly, so there is no auto-ack on take.

Parameters:
N_SRC, 4, number of interrupt sources (1..32); source 0 has highest priority
VEC_W, 32, width of handler vector / pc
ADDR_W, 3, register address width (4 when INTR_VECTOR_TABLE_EN and N_SRC>4)
ID_W, $clog2(N_SRC) (minimum 1), width of source id

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset; all state is cleared on the clk edge where reset=1
src_req  in  N_SRC  peripheral requests; a rising edge sets the pending bit
wr_en  in  1  register write strobe from the CPU intr instruction
wr_addr  in  ADDR_W  register index
wr_data  in  32  write data
rd_addr  in  ADDR_W  read index
rd_data  out  32  combinational read data
irq  out  1  registered interrupt request to the CPU
irq_id  out  ID_W  id of the requesting source; valid while irq=1
irq_vec  out  VEC_W  handler address; valid while irq=1
irq_take  in  1  CPU has trapped; ignored unless state=REQ
iret  in  1  CPU returned from the handler; ignored unless state=SERVICE
in_service  out  1  high in state SERVICE

Behaviour:
- Reset values: pending=0, enable=0, vec_base=0, src_prev=0, state=IDLE, irq=0, irq_id=0, irq_vec=0, in_service=0.
- Register map:
  - addr 0 PENDING: read returns pending; a write clears each bit set in wr_data (write-1-to-clear).
  - addr 1 ENABLE: read/write; uses wr_data[N_SRC-1:0].
  - addr 2 VECTOR: read/write; truncated to VEC_W.
  - addr 3 STATUS: read-only, {in_service at bit 31, irq at bit 30, irq_id at the LSBs}.
  - Unused read bits and unmapped reads return 0; writes to read-only or unmapped addresses are ignored.
- Edge detect: src_prev registered each cycle; pending[i] is set when src_req[i] & ~src_prev[i].
- Set and a W1C clear of the same bit in one cycle: set wins.
- FSM, three states:
  - IDLE: if (pending & enable) != 0, go to REQ. Latch irq_id = lowest set index and irq_vec. irq=1 from the next cycle.
  - REQ: irq_take moves to SERVICE, irq=0, in_service=1.
    - If (pending & enable) becomes 0 before the take (acked or disabled), return to IDLE with irq=0.
    - irq_id stays latched and is not re-arbitrated while in REQ.
  - SERVICE: iret moves to IDLE. New pending bits accumulate but are not signalled (no nesting).
- Latency: src edge sampled at edge t -> pending visible in cycle t+1 -> irq=1 in cycle t+2.
- Pending not acked before iret: irq re-asserts 1 cycle after returning to IDLE.
- irq_take and iret in the same cycle: only the one valid for the current state acts.
- Reset in the middle of REQ or SERVICE: forced to IDLE and all registers cleared.

Optional Feature:
INTR_VECTOR_TABLE_EN:
- Defined: per-source vector registers at addr 4+i, read/write. irq_vec = vec[irq_id]. VECTOR (addr 2) is unused and reads 0.
- Undefined: irq_vec = vec_base for every source. Addresses 4+ read 0 and ignore writes.

Decomposition:
- Package intr_pkg holds:
  - the address constants ADDR_PENDING=0, ADDR_ENABLE=1, ADDR_VECTOR=2, ADDR_STATUS=3, ADDR_VEC_TABLE=4;
  - the enum intr_state_t {IDLE, REQ, SERVICE};
  - the STATUS bit positions.
- One sub-module, intr_prio_enc: parametrised lowest-index priority encoder (N_SRC -> ID_W plus a valid flag), purely combinational.

Test Plan:
1. Reset, ENABLE=0b0010, VECTOR=9, pulse src_req[1] -> irq=1 exactly 2 cycles after the edge, irq_id=1, irq_vec=9; PENDING reads 0x2.
2. From case 1: irq_take -> irq=0, in_service=1; write PENDING=0x2, then iret -> irq stays 0 and PENDING reads 0.
3. Same as case 2 but skip the ack, then iret -> irq re-asserts 1 cycle later with irq_id=1.
4. ENABLE=0, pulse src_req[0] -> PENDING=0x1 and irq stays 0 for 20 cycles; then write ENABLE=1 -> irq=1 two cycles later.
5. ENABLE=0xF, pulse src_req[3] and src_req[2] in the same cycle -> irq_id=2. Take, ack 0x4, iret -> irq_id=3 next.
6. With INTR_VECTOR_TABLE_EN: vec[3]=0x40, vec[0]=0x20; pulse src_req[3] -> irq_vec=0x40. Assert reset while in SERVICE -> in_service=0, irq=0, and all registers read 0.
